// File: rtl/ex_mem_req_unit_pkg.sv
// Shared encodings for the EX-side memory request unit: access sizes, FSM states,
// strobe-width helper and per-size alignment masks.
package ex_mem_req_unit_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_HOLD   = 2'd2,
    ST_CANCEL = 2'd3
  } state_e;

  // Low address bits that must be zero for an access of each size
  localparam logic [2:0] ALIGN_B = 3'b000;
  localparam logic [2:0] ALIGN_H = 3'b001;
  localparam logic [2:0] ALIGN_W = 3'b011;
  localparam logic [2:0] ALIGN_D = 3'b111;

  function automatic int unsigned strb_w(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic logic [2:0] align_mask(input logic [1:0] size);
    logic [2:0] m;
    case (size)
      SZ_H:    m = ALIGN_H;
      SZ_W:    m = ALIGN_W;
      SZ_D:    m = ALIGN_D;
      default: m = ALIGN_B;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ex_mem_req_unit_mem_strb_gen.sv
// Combinational size/address/data decode: byte strobes, replicated store data and
// misalignment flag. Shared with the MEM-side load aligner.
module mem_strb_gen
  import ex_mem_req_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [1:0]              size,
  input  logic [2:0]              addr_low,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb_c,
  output logic [DATA_WIDTH-1:0]   wdata_rep_c,
  output logic                    adem_c
);

  localparam int unsigned STRB_W = strb_w(DATA_WIDTH);
  localparam int unsigned OFS_W  = $clog2(STRB_W);

  logic [7:0]       base_mask;
  logic [OFS_W-1:0] ofs;
  int unsigned      size_bytes;

  always_comb begin
    base_mask   = 8'h01;
    ofs         = addr_low[OFS_W-1:0];
    size_bytes  = 32'd1 << size;
    wdata_rep_c = '0;
    case (size)
      SZ_H:    base_mask = 8'h03;
      SZ_W:    base_mask = 8'h0F;
      SZ_D:    base_mask = 8'hFF;
      default: base_mask = 8'h01;
    endcase
    wstrb_c = STRB_W'(base_mask) << ofs;
    // Each lane repeats the byte at the same offset within the access-sized chunk
    for (int i = 0; i < int'(STRB_W); i++) begin
      wdata_rep_c[i*8 +: 8] = wdata[(i & int'(size_bytes - 32'd1))*8 +: 8];
    end
    adem_c = (|(addr_low & align_mask(size))) || ((size == SZ_D) && (DATA_WIDTH < 64));
  end

endmodule

// File: rtl/ex_mem_req_unit.sv
// EX-side memory request unit: captures ops, issues req/addr_ok bus requests held
// stable until accepted, forwards results to MEM. Optional counters: MEM_PERF_CNT_EN.
module ex_mem_req_unit
  import ex_mem_req_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    kill,
  input  logic                    in_valid,
  output logic                    in_allow,
  input  logic                    in_is_load,
  input  logic                    in_is_store,
  input  logic [1:0]              in_size,
  input  logic                    in_signed,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [DATA_WIDTH-1:0]   in_wdata,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    req,
  output logic                    req_wr,
  output logic [1:0]              req_size,
  output logic [ADDR_WIDTH-1:0]   req_addr,
  output logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic                    addr_ok,
  output logic                    out_valid,
  input  logic                    mem_allow_in,
  output logic [TAG_WIDTH-1:0]    out_tag,
  output logic [2:0]              out_addr_low,
  output logic [1:0]              out_size,
  output logic                    out_signed,
  output logic                    out_is_load,
  output logic                    out_ex_adem,
  output logic                    out_req_sent,
  output logic [31:0]             perf_req_cnt,
  output logic [31:0]             perf_stall_cnt,
  output logic [31:0]             perf_adem_cnt
);

  localparam int unsigned STRB_W = strb_w(DATA_WIDTH);

  state_e state_q, state_d;

  logic                  capture_c, mem_op_c, adem_c, req_c;
  logic                  gen_adem_c;
  logic [STRB_W-1:0]     gen_wstrb_c;
  logic [DATA_WIDTH-1:0] gen_wdata_c;

  logic                  req_wr_q, req_wr_d;
  logic [1:0]            size_q, size_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [2:0]            addr_low_q, addr_low_d;
  logic                  signed_q, signed_d;
  logic                  is_load_q, is_load_d;
  logic                  adem_q, adem_d;
  logic                  req_sent_q, req_sent_d;

  mem_strb_gen #(.DATA_WIDTH(DATA_WIDTH)) u_strb_gen (
    .size        (in_size),
    .addr_low    (in_addr[2:0]),
    .wdata       (in_wdata),
    .wstrb_c     (gen_wstrb_c),
    .wdata_rep_c (gen_wdata_c),
    .adem_c      (gen_adem_c)
  );

  assign mem_op_c = in_is_load | in_is_store;
  assign adem_c   = mem_op_c & gen_adem_c;
  assign req_c    = (state_q == ST_REQ) || (state_q == ST_CANCEL);

  // Next state, input handshake and capture
  always_comb begin
    state_d    = state_q;
    in_allow   = 1'b0;
    req_sent_d = req_sent_q;
    unique case (state_q)
      ST_IDLE: in_allow = 1'b1;
      ST_REQ: begin
        if (flush)        state_d = addr_ok ? ST_IDLE : ST_CANCEL;
        else if (addr_ok) begin
          state_d    = ST_HOLD;
          req_sent_d = 1'b1;
        end
      end
      ST_HOLD: begin
        in_allow = mem_allow_in;
        if (flush || mem_allow_in) state_d = ST_IDLE;
      end
      ST_CANCEL: if (addr_ok) state_d = ST_IDLE;
    endcase
    capture_c = in_valid & in_allow & ~flush;
    if (capture_c) begin
      state_d    = (mem_op_c && !adem_c && !kill) ? ST_REQ : ST_HOLD;
      req_sent_d = 1'b0;
    end
  end

  // Payload is loaded only on capture so it stays stable through REQ/CANCEL
  always_comb begin
    req_wr_d   = req_wr_q;
    size_d     = size_q;
    req_addr_d = req_addr_q;
    wstrb_d    = wstrb_q;
    wdata_d    = wdata_q;
    tag_d      = tag_q;
    addr_low_d = addr_low_q;
    signed_d   = signed_q;
    is_load_d  = is_load_q;
    adem_d     = adem_q;
    if (capture_c) begin
      req_wr_d   = in_is_store;
      size_d     = in_size;
      req_addr_d = in_addr & ~ADDR_WIDTH'(STRB_W - 1);
      wstrb_d    = in_is_store ? gen_wstrb_c : '0;
      wdata_d    = in_is_store ? gen_wdata_c : '0;
      tag_d      = in_tag;
      addr_low_d = in_addr[2:0];
      signed_d   = in_signed;
      is_load_d  = in_is_load;
      adem_d     = adem_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      req_wr_q   <= 1'b0;
      size_q     <= 2'd0;
      req_addr_q <= '0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
      tag_q      <= '0;
      addr_low_q <= 3'd0;
      signed_q   <= 1'b0;
      is_load_q  <= 1'b0;
      adem_q     <= 1'b0;
      req_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_wr_q   <= req_wr_d;
      size_q     <= size_d;
      req_addr_q <= req_addr_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
      tag_q      <= tag_d;
      addr_low_q <= addr_low_d;
      signed_q   <= signed_d;
      is_load_q  <= is_load_d;
      adem_q     <= adem_d;
      req_sent_q <= req_sent_d;
    end
  end

  assign req          = req_c;
  assign req_wr       = req_wr_q;
  assign req_size     = size_q;
  assign req_addr     = req_addr_q;
  assign req_wstrb    = wstrb_q;
  assign req_wdata    = wdata_q;
  assign out_valid    = (state_q == ST_HOLD);
  assign out_tag      = tag_q;
  assign out_addr_low = addr_low_q;
  assign out_size     = size_q;
  assign out_signed   = signed_q;
  assign out_is_load  = is_load_q;
  assign out_ex_adem  = adem_q;
  assign out_req_sent = req_sent_q;

`ifdef MEM_PERF_CNT_EN
  logic [31:0] perf_req_q, perf_req_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_adem_q, perf_adem_d;

  // Free-running wrap-around counters; flush does not clear them
  always_comb begin
    perf_req_d   = perf_req_q + 32'(req_c & addr_ok);
    perf_stall_d = perf_stall_q + 32'(req_c & ~addr_ok);
    perf_adem_d  = perf_adem_q + 32'(capture_c & adem_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_req_q   <= '0;
      perf_stall_q <= '0;
      perf_adem_q  <= '0;
    end else begin
      perf_req_q   <= perf_req_d;
      perf_stall_q <= perf_stall_d;
      perf_adem_q  <= perf_adem_d;
    end
  end

  assign perf_req_cnt   = perf_req_q;
  assign perf_stall_cnt = perf_stall_q;
  assign perf_adem_cnt  = perf_adem_q;
`else
  assign perf_req_cnt   = 32'd0;
  assign perf_stall_cnt = 32'd0;
  assign perf_adem_cnt  = 32'd0;
`endif

endmodule
